// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - column-serial AES SubBytes, 4 shared S-boxes, 4-cycle latency
// Optional inverse S-box and inv port: define SUB_BYTES_INV_EN.
module sub_bytes_serial (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
`ifdef SUB_BYTES_INV_EN
  ,
  input  logic         inv
`endif
);

  localparam logic [0:255][7:0] SBOX_FWD = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  logic r_mode;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [127:0]  r_data;
  logic [31:0]   w_col;
  logic [31:0]   w_sub;
  logic          w_in_fire;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign data_out  = r_data;
  assign w_in_fire = in_valid && in_ready;

  // Column cnt feeds the four shared S-boxes.
  always_comb begin
    w_col = r_data[127:96];
    case (r_cnt)
      2'd0: w_col = r_data[127:96];
      2'd1: w_col = r_data[95:64];
      2'd2: w_col = r_data[63:32];
      2'd3: w_col = r_data[31:0];
      default: w_col = r_data[127:96];
    endcase
  end

  always_comb begin
    w_sub = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef SUB_BYTES_INV_EN
      w_sub[31-8*i -: 8] = r_mode ? SBOX_INV[w_col[31-8*i -: 8]] : SBOX_FWD[w_col[31-8*i -: 8]];
`else
      w_sub[31-8*i -: 8] = SBOX_FWD[w_col[31-8*i -: 8]];
`endif
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_data  <= '0;
`ifdef SUB_BYTES_INV_EN
      r_mode  <= 1'b0;
`endif
    end else if (w_in_fire) begin
      // Covers both IDLE accept and the DONE->BUSY handoff with no bubble.
      r_state <= S_BUSY;
      r_cnt   <= 2'd0;
      r_data  <= data_in;
`ifdef SUB_BYTES_INV_EN
      r_mode  <= inv;
`endif
    end else begin
      case (r_state)
        S_BUSY: begin
          case (r_cnt)
            2'd0: r_data[127:96] <= w_sub;
            2'd1: r_data[95:64]  <= w_sub;
            2'd2: r_data[63:32]  <= w_sub;
            2'd3: r_data[31:0]   <= w_sub;
            default: r_data[127:96] <= w_sub;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb/tb_sub_bytes_serial.sv - randomized self-checking bench for sub_bytes_serial
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_serial;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] data_out;
`ifdef SUB_BYTES_INV_EN
  logic         inv = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 CLK = ~CLK;

  sub_bytes_serial dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out)
`ifdef SUB_BYTES_INV_EN
    , .inv(inv)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic void build_tables();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b = 8'(v);
      logic [7:0] r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, b);
      if (v == 0) r = 8'h00;
      fwd_t[v] = r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) inv_t[fwd_t[v]] = 8'(v);
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = m ? inv_t[d[127-8*k -: 8]] : fwd_t[d[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d);
    int t = 0;
    in_valid = 1'b1;
    data_in  = d;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    data_in  = rand128();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [127:0] d, input logic m, input logic [127:0] exp);
    int lat;
`ifdef SUB_BYTES_INV_EN
    inv = m;
`endif
    send(d);
    wait_done(lat);
    n_checks++;
    if (lat != 4 || data_out !== exp) begin
      n_fail++;
      $display("FAIL %s: latency=%0d data_out=%h required latency=4 data_out=%h", name, lat, data_out, exp);
    end
    consume();
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b data_out=%h required 1 0 0", in_ready, out_valid, data_out);
    end
  endtask

  task automatic test_fips();
    run_block("fips_b_round1", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
              128'hd42711aee0bf98f1b8b45de51e415230);
    run_block("all_zero", 128'h0, 1'b0, {16{8'h63}});
  endtask

  task automatic test_sweep();
    int lat;
    for (int b = 0; b < 16; b++) begin
      logic [127:0] d;
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(16*b + k);
      send(d);
      wait_done(lat);
      n_checks++;
      if (lat != 4 || data_out !== ref_sub(d, 1'b0)) begin
        n_fail++;
        $display("FAIL sweep_%0d: latency=%0d data_out=%h required latency=4 data_out=%h", b, lat, data_out, ref_sub(d, 1'b0));
      end
      if (b == 0) begin
        n_checks++;
        if (data_out[119:112] !== 8'h7c) begin
          n_fail++;
          $display("FAIL sbox_01: got %h required 7c", data_out[119:112]);
        end
      end
      if (b == 5) begin
        n_checks++;
        if (data_out[103:96] !== 8'hed) begin
          n_fail++;
          $display("FAIL sbox_53: got %h required ed", data_out[103:96]);
        end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a = rand128();
    logic [127:0] b = rand128();
    int lat;
    int bad = 0;
    send(a);
    wait_done(lat);
    in_valid = 1'b1;
    data_in  = b;
    for (int c = 0; c < 10; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== ref_sub(a, 1'b0)) bad++;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles required 0 (data_out=%h)", bad, data_out);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1 1", in_ready, out_valid);
    end
    @(posedge CLK); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_done(lat);
    n_checks++;
    if (lat != 4 || data_out !== ref_sub(b, 1'b0)) begin
      n_fail++;
      $display("FAIL backpressure_next: latency=%0d data_out=%h required latency=4 data_out=%h", lat, data_out, ref_sub(b, 1'b0));
    end
    consume();
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] x = rand128();
    send(x);
    @(posedge CLK); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b data_out=%h required 1 0 0", in_ready, out_valid, data_out);
    end
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;
    x = rand128();
    run_block("after_reset", x, 1'b0, ref_sub(x, 1'b0));
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q[$];
    int sent = 0, recv = 0, cyc = 0, last_out = -1;
    logic in_fire, out_fire;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = rand128();
    while (recv < 8 && cyc < 200) begin
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        logic [127:0] e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL b2b_data_%0d: data_out=%h required %h", recv, data_out, e);
        end
        if (last_out >= 0) begin
          n_checks++;
          if (cyc - last_out != 5) begin
            n_fail++;
            $display("FAIL b2b_interval_%0d: got %0d cycles required 5", recv, cyc - last_out);
          end
        end
        last_out = cyc;
        recv++;
      end
      if (in_fire) begin
        exp_q.push_back(ref_sub(data_in, 1'b0));
        sent++;
      end
      @(posedge CLK); #1;
      cyc++;
      if (in_fire) begin
        if (sent == 8) in_valid = 1'b0;
        else data_in = rand128();
      end
    end
    n_checks++;
    if (recv != 8) begin
      n_fail++;
      $display("FAIL b2b_count: received %0d required 8", recv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge CLK); #1;
  endtask

`ifdef SUB_BYTES_INV_EN
  task automatic test_inverse();
    logic [127:0] r = rand128();
    int lat;
    run_block("inv_all_63", {16{8'h63}}, 1'b1, 128'h0);
    r[127:120] = 8'hed;
    run_block("inv_ed", r, 1'b1, ref_sub(r, 1'b1));
    r = rand128();
    inv = 1'b1;
    send(r);
    inv = 1'b0;
    wait_done(lat);
    n_checks++;
    if (lat != 4 || data_out !== ref_sub(r, 1'b1)) begin
      n_fail++;
      $display("FAIL inv_toggle_busy: data_out=%h required %h", data_out, ref_sub(r, 1'b1));
    end
    consume();
  endtask
`endif

  initial begin
    build_tables();
    #12;
    test_reset();
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK); #1;
    test_fips();
    test_sweep();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef SUB_BYTES_INV_EN
    test_inverse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
